noise_signal_gen: RTL and testbench

Burst generator for the noise tester. A single `start` pulse arms a fixed-length burst, paced by the external low-rate tick input `clk_100`. During the burst the block drives a complementary pair of square-wave outputs (`out_1`/`out_2`), holds `enable` high and exposes a 10-bit tick counter. It sits between the test-sequencing logic and the noise-injection driver stage.

---
 rtl/signal_gen_pkg.sv | 16 +
 rtl/sync_edge_det.sv | 30 +++
 rtl/noise_signal_gen.sv | 125 ++++++++++++
 tb/tb_noise_signal_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/signal_gen_pkg.sv
// Shared types and defaults for the noise tester burst generator.
// Optional dead-time insertion is selected by the SIGNAL_GEN_DEADTIME_EN macro.
`timescale 1ns/1ps
package signal_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } gen_state_e;

  localparam int COUNT_W         = 10;
  localparam int DEF_BURST_LEN   = 200;
  localparam int DEF_DEAD_CYCLES = 4;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, followed by a registered
// rising-edge pulse (one clk cycle wide, three cycles after the input edge).
`timescale 1ns/1ps
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic rise_pulse
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      sync_p2    <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync_p0    <= d_async;
      sync_p1    <= sync_p0;
      // edge register stage
      sync_p2    <= sync_p1;
      rise_pulse <= sync_p1 & ~sync_p2;
    end
  end

endmodule

// File: rtl/noise_signal_gen.sv
// Burst generator: a start edge arms a BURST_LEN-tick burst of complementary
// square waves paced by clk_100. Define SIGNAL_GEN_DEADTIME_EN for non-overlap.
`timescale 1ns/1ps
module noise_signal_gen
  import signal_gen_pkg::*;
#(
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_100,
  input  logic               start,
  output logic               enable,
  output logic               out_1,
  output logic               out_2,
  output logic [COUNT_W-1:0] count
);

  localparam logic [COUNT_W-1:0] LAST_CNT = COUNT_W'(BURST_LEN - 1);
  localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(BURST_LEN);

  if (BURST_LEN < 2 || BURST_LEN > 1023 || DEAD_CYCLES < 1) begin : g_bad_cfg
    $error("noise_signal_gen: BURST_LEN must be 2..1023 and DEAD_CYCLES >= 1");
  end

  logic tick;
  logic start_evt;

  sync_edge_det u_tick_det (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_async    (clk_100),
    .rise_pulse (tick)
  );

  sync_edge_det u_start_det (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_async    (start),
    .rise_pulse (start_evt)
  );

  gen_state_e state;

`ifdef SIGNAL_GEN_DEADTIME_EN
  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES);

  // phase is the level out_1 will take once the dead window closes
  logic              phase;
  logic [DEAD_W-1:0] dead_cnt;
`endif

  // output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      enable   <= 1'b0;
      out_1    <= 1'b0;
      out_2    <= 1'b0;
      count    <= '0;
`ifdef SIGNAL_GEN_DEADTIME_EN
      phase    <= 1'b0;
      dead_cnt <= '0;
`endif
    end else begin
`ifdef SIGNAL_GEN_DEADTIME_EN
      if (dead_cnt != '0) begin
        dead_cnt <= dead_cnt - DEAD_W'(1);
        if (dead_cnt == DEAD_W'(1)) begin
          out_1 <= phase;
          out_2 <= ~phase;
        end
      end
`endif
      case (state)
        IDLE: begin
          if (start_evt) begin
            state <= ARM;
            count <= '0;
          end
        end
        ARM: begin
          if (tick) begin
            state  <= RUN;
            enable <= 1'b1;
            out_1  <= 1'b1;
            out_2  <= 1'b0;
`ifdef SIGNAL_GEN_DEADTIME_EN
            phase  <= 1'b1;
`endif
          end
        end
        RUN: begin
          if (tick) begin
            if (count == LAST_CNT) begin
              state    <= IDLE;
              count    <= FULL_CNT;
              enable   <= 1'b0;
              out_1    <= 1'b0;
              out_2    <= 1'b0;
`ifdef SIGNAL_GEN_DEADTIME_EN
              dead_cnt <= '0;
`endif
            end else begin
              count    <= count + COUNT_W'(1);
`ifdef SIGNAL_GEN_DEADTIME_EN
              phase    <= ~phase;
              out_1    <= 1'b0;
              out_2    <= 1'b0;
              dead_cnt <= DEAD_LOAD;
`else
              out_1    <= ~out_1;
              out_2    <= out_1;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noise_signal_gen.sv
// Self-checking bench for noise_signal_gen: table of burst scenarios plus
// hand-written corner sequences, all compared every cycle to a reference model.
`timescale 1ns/1ps
module tb_noise_signal_gen;
  import signal_gen_pkg::*;

  localparam int BURST_LEN = 200;
  localparam int DEAD      = 4;
  localparam int TICK_CYC  = 20;
`ifdef SIGNAL_GEN_DEADTIME_EN
  localparam int MODEL_DEAD = DEAD;
`else
  localparam int MODEL_DEAD = 0;
`endif

  logic               clk     = 1'b0;
  logic               rst_n   = 1'b0;
  logic               clk_100 = 1'b0;
  logic               start   = 1'b0;
  logic               enable;
  logic               out_1;
  logic               out_2;
  logic [COUNT_W-1:0] count;

  int n_pass  = 0;
  int n_total = 0;

  noise_signal_gen #(.BURST_LEN(BURST_LEN), .DEAD_CYCLES(DEAD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_100 (clk_100),
    .start   (start),
    .enable  (enable),
    .out_1   (out_1),
    .out_2   (out_2),
    .count   (count)
  );

  always #10 clk = ~clk;

  // Pacing signal: TICK_CYC clk periods, updated on falling clk edges.
  int tph = 0;
  initial begin
    forever begin
      @(negedge clk);
      tph     = (tph == TICK_CYC - 1) ? 0 : tph + 1;
      clk_100 = (tph < TICK_CYC / 2);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d at %0t", name, got, exp, $time);
  endtask

  // Reference model: a tick or start edge is acted on 3 cycles after the
  // bench-side rise; state is kept as idle/armed/running plus tick count.
  int       m_state = 0;
  int       m_count = 0;
  bit       m_o1    = 1'b0;
  int       m_dz    = 0;
  bit [3:0] th      = '0;
  bit [3:0] sh      = '0;
  bit       m_tk, m_st;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_state = 0; m_count = 0; m_o1 = 1'b0; m_dz = 0; th = '0; sh = '0;
      end else begin
        m_tk = th[2] & ~th[3];
        m_st = sh[2] & ~sh[3];
        th   = {th[2:0], clk_100};
        sh   = {sh[2:0], start};
        if (m_dz > 0) m_dz--;
        if (m_state == 0) begin
          if (m_st) begin m_state = 1; m_count = 0; end
        end else if (m_state == 1) begin
          if (m_tk) begin m_state = 2; m_o1 = 1'b1; end
        end else begin
          if (m_tk) begin
            m_count++;
            if (m_count == BURST_LEN) begin
              m_state = 0; m_o1 = 1'b0; m_dz = 0;
            end else begin
              m_o1 = ~m_o1; m_dz = MODEL_DEAD;
            end
          end
        end
      end
    end
  end

  // Per-cycle scoreboard
  bit          sb_on = 1'b0;
  logic [12:0] sb_got, sb_exp;
  bit          e_en;
  initial begin
    forever begin
      @(negedge clk);
      if (sb_on) begin
        e_en   = (m_state == 2);
        sb_exp = {e_en, e_en & m_o1 & (m_dz == 0), e_en & ~m_o1 & (m_dz == 0), COUNT_W'(m_count)};
        sb_got = {enable, out_1, out_2, count};
        n_total++;
        if (sb_got === sb_exp) n_pass++;
        else $display("FAIL cycle {en,o1,o2,count}: got %b/%0d required %b/%0d at %0t",
                      sb_got[12:10], sb_got[9:0], sb_exp[12:10], sb_exp[9:0], $time);
      end
    end
  end

  time t_en = 0;
  always @(posedge enable) t_en = $time;

  task automatic pulse_start(input int width);
    start = 1'b1;
    repeat (width) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_burst_end(input string name);
    bit done = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < (BURST_LEN + 4) * TICK_CYC; i++) begin
      if (!enable && count == COUNT_W'(BURST_LEN)) begin done = 1'b1; break; end
      @(negedge clk);
    end
    check({name, "_end_reached"}, {31'd0, done}, 32'd1);
  endtask

  typedef struct {
    int gap;
    int start_w;
    int retrig_cyc;
    int rst_cyc;
    int exp_count;
    bit exp_en;
  } vec_t;

  vec_t vecs[6];
  time  t_rise;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #50;
    check("rst_enable", {31'd0, enable}, 32'd0);
    check("rst_out_1",  {31'd0, out_1},  32'd0);
    check("rst_out_2",  {31'd0, out_2},  32'd0);
    check("rst_count",  {22'd0, count},  32'd0);
    #55 rst_n = 1'b1;
    sb_on = 1'b1;

    // first burst: start well ahead of a tick, measure enable latency
    do @(posedge clk); while (tph != 2);
    @(negedge clk);
    pulse_start(1);
    @(posedge clk_100) t_rise = $time;
    repeat (6) @(negedge clk);
    check("enable_latency_ns", 32'(t_en - t_rise), 32'd70);
    check("first_out_1", {31'd0, out_1}, 32'd1);
    check("first_out_2", {31'd0, out_2}, 32'd0);
    check("first_count", {22'd0, count}, 32'd0);
    wait_burst_end("burst0");
    repeat ($urandom_range(5, 60)) @(negedge clk);
    check("hold_count", {22'd0, count}, BURST_LEN);
    check("hold_enable", {31'd0, enable}, 32'd0);

    // scenario table
    vecs[0] = '{$urandom_range(1, 40), 1, 0, 0, BURST_LEN, 1'b0};
    vecs[1] = '{$urandom_range(1, 40), 3, TICK_CYC * 60, 0, BURST_LEN, 1'b0};
    vecs[2] = '{$urandom_range(1, 40), $urandom_range(1, 3),
                $urandom_range(TICK_CYC * 2, TICK_CYC * 190), 0, BURST_LEN, 1'b0};
    vecs[3] = '{$urandom_range(1, 40), 1, 0, TICK_CYC * 100, 0, 1'b0};
    vecs[4] = '{$urandom_range(1, 40), 2, 0, 0, BURST_LEN, 1'b0};
    vecs[5] = '{$urandom_range(1, 40), 1, 3, 0, BURST_LEN, 1'b0};

    for (int i = 0; i < 6; i++) begin
      repeat (vecs[i].gap) @(negedge clk);
      pulse_start(vecs[i].start_w);
      if (vecs[i].retrig_cyc > 0) begin
        repeat (vecs[i].retrig_cyc) @(negedge clk);
        pulse_start(1);
      end
      if (vecs[i].rst_cyc > 0) begin
        repeat (vecs[i].rst_cyc) @(negedge clk);
        #5 rst_n = 1'b0;
        #1;
        check($sformatf("vec%0d_async_rst_outs", i), {29'd0, enable, out_1, out_2}, 32'd0);
        check($sformatf("vec%0d_async_rst_count", i), {22'd0, count}, 32'd0);
        #40;
        @(negedge clk);
        #5 rst_n = 1'b1;
      end else begin
        wait_burst_end($sformatf("vec%0d", i));
      end
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_count", i), {22'd0, count}, vecs[i].exp_count);
      check($sformatf("vec%0d_enable", i), {31'd0, enable}, {31'd0, vecs[i].exp_en});
    end

    // start edge and tick detected in the same idle cycle: tick not consumed
    do @(posedge clk); while (tph != TICK_CYC - 1);
    @(negedge clk);
    pulse_start(1);
    repeat (6) @(negedge clk);
    check("same_cycle_still_armed", {31'd0, enable}, 32'd0);
    check("same_cycle_count_cleared", {22'd0, count}, 32'd0);
    repeat (TICK_CYC) @(negedge clk);
    check("same_cycle_next_tick_runs", {31'd0, enable}, 32'd1);
    wait_burst_end("same_cycle");
    check("same_cycle_final_count", {22'd0, count}, BURST_LEN);

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
